// File: rtl/tmds_pkg.sv
// Shared types, symbol constants and lookup helpers for the TMDS lane encoder.
// Bit 0 of every 10-bit code is the first bit on the wire.
package tmds_pkg;

   typedef enum logic [2:0] {
      MODE_CTRL  = 3'd0,
      MODE_VIDEO = 3'd1,
      MODE_VGB   = 3'd2,
      MODE_TERC4 = 3'd3,
      MODE_DIGB  = 3'd4
   } tmds_mode_t;

   // Carries one symbol from the q_m stage to the DC-balance stage.
   typedef struct packed {
      tmds_mode_t mode;
      logic [1:0] ctrl;
      logic [3:0] aux;
      logic [8:0] q_m;
   } s1_t;

   localparam logic [9:0] CTRL_00 = 10'b1101010100;
   localparam logic [9:0] CTRL_01 = 10'b0010101011;
   localparam logic [9:0] CTRL_10 = 10'b0101010100;
   localparam logic [9:0] CTRL_11 = 10'b1010101011;

   localparam logic [9:0] VGB_A = 10'b1011001100;
   localparam logic [9:0] VGB_B = 10'b0100110011;

   localparam s1_t S1_RESET = '{mode: MODE_CTRL, ctrl: 2'b00, aux: 4'h0, q_m: 9'h000};

   function automatic logic [9:0] ctrl_code(input logic [1:0] ctrl);
      logic [9:0] code;
      case (ctrl)
         2'b00:   code = CTRL_00;
         2'b01:   code = CTRL_01;
         2'b10:   code = CTRL_10;
         default: code = CTRL_11;
      endcase
      return code;
   endfunction

   function automatic logic [9:0] terc4_code(input logic [3:0] nib);
      logic [9:0] code;
      case (nib)
         4'h0:    code = 10'b1010011100;
         4'h1:    code = 10'b1001100011;
         4'h2:    code = 10'b1011100100;
         4'h3:    code = 10'b1011100010;
         4'h4:    code = 10'b0101110001;
         4'h5:    code = 10'b0100011110;
         4'h6:    code = 10'b0110001110;
         4'h7:    code = 10'b0100111100;
         4'h8:    code = 10'b1011001100;
         4'h9:    code = 10'b0100111001;
         4'hA:    code = 10'b0110011100;
         4'hB:    code = 10'b1011000110;
         4'hC:    code = 10'b1010001110;
         4'hD:    code = 10'b1001110001;
         4'hE:    code = 10'b0101100011;
         default: code = 10'b1011000011;
      endcase
      return code;
   endfunction

   // Codes 5..7 are undefined and fold onto control symbols.
   function automatic tmds_mode_t mode_decode(input logic [2:0] m);
      tmds_mode_t mode;
      if (m > 3'd4) mode = MODE_CTRL;
      else          mode = tmds_mode_t'(m);
      return mode;
   endfunction

endpackage

// File: rtl/tmds_qm_stage.sv
// Transition-minimising stage: builds the 9-bit q_m word from one pixel byte.
// q_m[8] is 1 when the XOR chain was used and 0 for XNOR.
module tmds_qm_stage (
   input  logic [7:0] data_i,
   output logic [8:0] q_m_o
);

   logic [3:0] n1;
   logic       use_xnor;
   logic [8:0] q;

   always_comb begin
      n1 = '0;
      for (int unsigned i = 0; i < 8; i++) begin
         n1 = n1 + {3'b000, data_i[i]};
      end
      use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !data_i[0]);

      q    = '0;
      q[0] = data_i[0];
      for (int unsigned i = 1; i < 8; i++) begin
         q[i] = use_xnor ? ~(q[i-1] ^ data_i[i]) : (q[i-1] ^ data_i[i]);
      end
      q[8] = ~use_xnor;
      q_m_o = q;
   end

endmodule

// File: rtl/tmds_channel_encoder.sv
// Per-lane TMDS encoder: control, 8b/10b video with DC balance, guard bands
// and TERC4, with an optional register between the q_m and balance stages.
module tmds_channel_encoder
   import tmds_pkg::*;
#(
   parameter int CHANNEL     = 0,
   parameter int PIPE_STAGES = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] mode_in,
   input  logic [7:0] data_in,
   input  logic [1:0] ctrl_in,
   input  logic [3:0] aux_in,
   output logic [9:0] tmds_out,
   output logic [5:0] bias_out
);

   localparam logic [9:0] VGB_SYM = (CHANNEL == 1) ? VGB_B : VGB_A;

   logic [8:0]        q_m;
   s1_t               s1_in;
   s1_t               s1;
   logic [3:0]        n1_qm;
   logic signed [5:0] disp;
   logic [9:0]        tmds_d, tmds_q;
   logic signed [5:0] bias_d, bias_q;

   if ((CHANNEL < 0) || (CHANNEL > 2)) begin : g_bad_channel
      $error("tmds_channel_encoder: CHANNEL must be 0, 1 or 2");
   end

   tmds_qm_stage u_qm (
      .data_i (data_in),
      .q_m_o  (q_m)
   );

   assign s1_in = '{mode: mode_decode(mode_in), ctrl: ctrl_in, aux: aux_in, q_m: q_m};

   if (PIPE_STAGES == 2) begin : g_pipe
      s1_t s1_q;
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) s1_q <= S1_RESET;
         else        s1_q <= s1_in;
      end
      assign s1 = s1_q;
   end else begin : g_comb
      if (PIPE_STAGES != 1) begin : g_bad_pipe
         $error("tmds_channel_encoder: PIPE_STAGES must be 1 or 2");
      end
      assign s1 = s1_in;
   end

   // disp = N1 - N0 over q_m[7:0] = 2*N1 - 8; always even.
   always_comb begin
      n1_qm = '0;
      for (int unsigned i = 0; i < 8; i++) begin
         n1_qm = n1_qm + {3'b000, s1.q_m[i]};
      end
      disp   = $signed({1'b0, n1_qm, 1'b0}) - 6'sd8;
      tmds_d = ctrl_code(s1.ctrl);
      bias_d = '0;
      case (s1.mode)
         MODE_VIDEO: begin
            if ((bias_q == 6'sd0) || (disp == 6'sd0)) begin
               tmds_d = {~s1.q_m[8], s1.q_m[8], s1.q_m[8] ? s1.q_m[7:0] : ~s1.q_m[7:0]};
               bias_d = s1.q_m[8] ? (bias_q + disp) : (bias_q - disp);
            end else if (bias_q[5] == disp[5]) begin
               tmds_d = {1'b1, s1.q_m[8], ~s1.q_m[7:0]};
               bias_d = bias_q - disp + (s1.q_m[8] ? 6'sd2 : 6'sd0);
            end else begin
               tmds_d = {1'b0, s1.q_m[8], s1.q_m[7:0]};
               bias_d = bias_q + disp - (s1.q_m[8] ? 6'sd0 : 6'sd2);
            end
         end
         MODE_VGB:   tmds_d = VGB_SYM;
         MODE_TERC4: tmds_d = terc4_code(s1.aux);
         MODE_DIGB:  tmds_d = (CHANNEL == 0) ? terc4_code({2'b11, s1.ctrl}) : VGB_B;
         default:    ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmds_q <= CTRL_00;
         bias_q <= '0;
      end else begin
         tmds_q <= tmds_d;
         bias_q <= bias_d;
      end
   end

   assign tmds_out = tmds_q;
   assign bias_out = bias_q;

   a_bias_even : assert property (@(posedge clk) disable iff (!rst_n) !bias_q[0]);
   a_bias_range : assert property (@(posedge clk) disable iff (!rst_n)
      (bias_q <= 6'sd16) && (bias_q >= -6'sd16));

endmodule

// File: tb/tb_tmds_channel_encoder.sv
// Randomised self-checking bench: three PIPE_STAGES=1 lanes (channels 0..2) and
// one PIPE_STAGES=2 lane share stimulus and are compared to a behavioural model.
module tb_tmds_channel_encoder;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [2:0] mode_in;
   logic [7:0] data_in;
   logic [1:0] ctrl_in;
   logic [3:0] aux_in;
   logic [9:0] t0, t1, t2, tp;
   logic [5:0] b0, b1, b2, bp;

   int checks   = 0;
   int failures = 0;

   int         mb;
   logic [9:0] prev_sym;
   int         prev_bias;

   localparam logic [9:0] R_CTL [4] = '{10'b1101010100, 10'b0010101011,
                                        10'b0101010100, 10'b1010101011};
   localparam logic [9:0] R_TERC [16] = '{
      10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
      10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
      10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
      10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011};
   localparam logic [9:0] R_GB_A = 10'b1011001100;
   localparam logic [9:0] R_GB_B = 10'b0100110011;

   always #5 clk = ~clk;

   tmds_channel_encoder #(.CHANNEL(0), .PIPE_STAGES(1)) u_c0 (
      .clk(clk), .rst_n(rst_n), .mode_in(mode_in), .data_in(data_in),
      .ctrl_in(ctrl_in), .aux_in(aux_in), .tmds_out(t0), .bias_out(b0));
   tmds_channel_encoder #(.CHANNEL(1), .PIPE_STAGES(1)) u_c1 (
      .clk(clk), .rst_n(rst_n), .mode_in(mode_in), .data_in(data_in),
      .ctrl_in(ctrl_in), .aux_in(aux_in), .tmds_out(t1), .bias_out(b1));
   tmds_channel_encoder #(.CHANNEL(2), .PIPE_STAGES(1)) u_c2 (
      .clk(clk), .rst_n(rst_n), .mode_in(mode_in), .data_in(data_in),
      .ctrl_in(ctrl_in), .aux_in(aux_in), .tmds_out(t2), .bias_out(b2));
   tmds_channel_encoder #(.CHANNEL(0), .PIPE_STAGES(2)) u_p2 (
      .clk(clk), .rst_n(rst_n), .mode_in(mode_in), .data_in(data_in),
      .ctrl_in(ctrl_in), .aux_in(aux_in), .tmds_out(tp), .bias_out(bp));

   task automatic chk(input string tag, input logic signed [31:0] obs,
                      input logic signed [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                  tag, obs, obs, exp, exp, $time);
      end
   endtask

   function automatic void ref_sym(input int ch, input logic [2:0] m, input logic [7:0] d,
                                   input logic [1:0] c, input logic [3:0] a, input int bias_in,
                                   output logic [9:0] sym, output int bias_nx);
      int         n1, ones, disp;
      logic       xn, q8;
      logic [7:0] q;
      bias_nx = 0;
      sym     = R_CTL[c];
      if (m == 3'd1) begin
         n1   = $countones(d);
         xn   = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
         q[0] = d[0];
         for (int i = 1; i < 8; i++) q[i] = xn ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
         q8   = ~xn;
         ones = $countones(q);
         disp = ones - (8 - ones);
         if (bias_in == 0 || disp == 0) begin
            sym     = {~q8, q8, q8 ? q : ~q};
            bias_nx = bias_in + (q8 ? disp : -disp);
         end else if ((bias_in > 0) == (disp > 0)) begin
            sym     = {1'b1, q8, ~q};
            bias_nx = bias_in + 2 * int'(q8) - disp;
         end else begin
            sym     = {1'b0, q8, q};
            bias_nx = bias_in + disp - 2 * int'(!q8);
         end
      end else if (m == 3'd2) begin
         sym = (ch == 1) ? R_GB_B : R_GB_A;
      end else if (m == 3'd3) begin
         sym = R_TERC[a];
      end else if (m == 3'd4) begin
         sym = (ch == 0) ? R_TERC[{2'b11, c}] : R_GB_B;
      end
   endfunction

   task automatic step(input logic [2:0] m, input logic [7:0] d,
                       input logic [1:0] c, input logic [3:0] a);
      logic [9:0] e [3];
      int         nb;
      @(negedge clk);
      mode_in = m; data_in = d; ctrl_in = c; aux_in = a;
      for (int ch = 0; ch < 3; ch++) ref_sym(ch, m, d, c, a, mb, e[ch], nb);
      @(posedge clk);
      #1;
      chk("c0_sym", {22'd0, t0}, {22'd0, e[0]});
      chk("c0_bias", $signed(b0), nb);
      chk("c1_sym", {22'd0, t1}, {22'd0, e[1]});
      chk("c1_bias", $signed(b1), nb);
      chk("c2_sym", {22'd0, t2}, {22'd0, e[2]});
      chk("p2_sym", {22'd0, tp}, {22'd0, prev_sym});
      chk("p2_bias", $signed(bp), prev_bias);
      chk("bias_even", {31'd0, b0[0]}, 0);
      chk("bias_range", ($signed(b0) <= 16 && $signed(b0) >= -16) ? 1 : 0, 1);
      mb        = nb;
      prev_sym  = e[0];
      prev_bias = nb;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_t0"}, {22'd0, t0}, {22'd0, R_CTL[0]});
      chk({tag, "_t1"}, {22'd0, t1}, {22'd0, R_CTL[0]});
      chk({tag, "_tp"}, {22'd0, tp}, {22'd0, R_CTL[0]});
      chk({tag, "_b0"}, $signed(b0), 0);
      chk({tag, "_bp"}, $signed(bp), 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1 chk_reset_outputs("rst_async");
      @(posedge clk);
      #1 chk_reset_outputs("rst_hold");
      rst_n     = 1'b1;
      mb        = 0;
      prev_sym  = R_CTL[0];
      prev_bias = 0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [2:0] m;
      int         r;
      rst_n = 1'b0; mode_in = 3'd0; data_in = 8'h00; ctrl_in = 2'b00; aux_in = 4'h0;
      mb = 0; prev_sym = R_CTL[0]; prev_bias = 0;
      repeat (2) @(posedge clk);
      #1 chk_reset_outputs("reset");
      do_reset();

      step(3'd1, 8'h00, 2'b00, 4'h0);
      chk("tp_v0_sym", {22'd0, t0}, 32'h100);  chk("tp_v0_bias", $signed(b0), -8);
      step(3'd1, 8'h00, 2'b00, 4'h0);
      chk("tp_v1_sym", {22'd0, t0}, 32'h3FF);  chk("tp_v1_bias", $signed(b0), 2);
      step(3'd1, 8'h00, 2'b00, 4'h0);
      chk("tp_v2_sym", {22'd0, t0}, 32'h100);  chk("tp_v2_bias", $signed(b0), -6);
      step(3'd0, 8'h00, 2'b01, 4'h0);
      chk("tp_ctl_sym", {22'd0, t0}, {22'd0, 10'b0010101011});
      chk("tp_ctl_bias", $signed(b0), 0);
      step(3'd1, 8'h00, 2'b00, 4'h0);
      chk("tp_v3_sym", {22'd0, t0}, 32'h100);  chk("tp_v3_bias", $signed(b0), -8);

      for (int n = 0; n < 16; n++) begin
         step(3'd3, 8'($urandom), 2'($urandom), 4'(n));
         chk("terc4_sweep", {22'd0, t0}, {22'd0, R_TERC[n]});
      end

      step(3'd4, 8'h00, 2'b10, 4'h0);
      chk("digb_c0", {22'd0, t0}, {22'd0, 10'b0101100011});
      chk("digb_c1", {22'd0, t1}, {22'd0, 10'b0100110011});
      step(3'd2, 8'h00, 2'b00, 4'h0);
      chk("vgb_c0", {22'd0, t0}, {22'd0, 10'b1011001100});
      chk("vgb_c1", {22'd0, t1}, {22'd0, 10'b0100110011});
      chk("vgb_c2", {22'd0, t2}, {22'd0, 10'b1011001100});
      step(3'd7, 8'h00, 2'b11, 4'h0);
      chk("mode7", {22'd0, t0}, {22'd0, 10'b1010101011});

      for (int n = 0; n < 24; n++) begin
         step((n % 2 == 0) ? 3'd1 : 3'd0, 8'($urandom), 2'($urandom), 4'($urandom));
      end

      for (int n = 0; n < 10000; n++) begin
         if (n == 5000) do_reset();
         r = $urandom_range(0, 15);
         if (r < 12) begin
            m = 3'd1;
         end else begin
            m = 3'($urandom_range(0, 7));
            if (m == 3'd1) m = 3'd0;
         end
         step(m, 8'($urandom), 2'($urandom), 4'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
